// File: rtl/ysyx_22050710_div_seq.sv
// Sequential restoring divider for RV64M div/rem, including the 32-bit W forms.
// It produces one quotient bit per cycle, and divide-by-zero and signed overflow complete in a single cycle.
module ysyx_22050710_div_seq (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [4:0]  i_ALUctr,
  input  logic        i_word_cut,
  input  logic [63:0] i_src1,
  input  logic [63:0] i_src2,
  input  logic        i_flush,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [63:0] o_result,
  output logic        o_busy
);

  localparam int unsigned XLEN  = 64;
  localparam int unsigned WLEN  = 32;
  localparam int unsigned CNT_W = 7;

  localparam logic [4:0] OP_DIV  = 5'b01011;
  localparam logic [4:0] OP_DIVU = 5'b01100;
  localparam logic [4:0] OP_REM  = 5'b01101;
  localparam logic [4:0] OP_REMU = 5'b01110;

  localparam logic [CNT_W-1:0] LAST_D = CNT_W'(XLEN - 1);
  localparam logic [CNT_W-1:0] LAST_W = CNT_W'(WLEN - 1);

  localparam logic [XLEN-1:0] MIN_D = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_W = {{(XLEN-WLEN+1){1'b1}}, {(WLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t            state_q, state_nx;
  logic [CNT_W-1:0]  cnt_q, cnt_nx;
  logic [XLEN-1:0]   quo_q, quo_nx;
  logic [XLEN-1:0]   rem_q, rem_nx;
  logic [XLEN-1:0]   dvs_q, dvs_nx;
  logic              is_rem_q, is_rem_nx;
  logic              word_q, word_nx;
  logic              q_neg_q, q_neg_nx;
  logic              r_neg_q, r_neg_nx;
  logic [XLEN-1:0]   res_nx;

  logic              op_ok_c, in_signed_c, in_rem_c;
  logic [XLEN-1:0]   a_ext_c, b_ext_c, a_mag_c, b_mag_c;
  logic              a_neg_c, b_neg_c, div_zero_c, ovf_c;
  logic [XLEN-1:0]   special_c;
  logic [XLEN:0]     partial_c, diff_c;
  logic              ge_c;
  logic [XLEN-1:0]   step_quo_c, step_rem_c, final_c;

  // W results always carry bit 31 into the upper half, signed or not
  function automatic logic [XLEN-1:0] fit(input logic [XLEN-1:0] x, input logic w);
    return w ? {{(XLEN-WLEN){x[WLEN-1]}}, x[WLEN-1:0]} : x;
  endfunction

  function automatic logic [XLEN-1:0] neg(input logic [XLEN-1:0] x);
    return ~x + XLEN'(1);
  endfunction

  // Request decode: operand extension, magnitudes and single-cycle special cases
  always_comb begin
    op_ok_c     = (i_ALUctr == OP_DIV) || (i_ALUctr == OP_DIVU) ||
                  (i_ALUctr == OP_REM) || (i_ALUctr == OP_REMU);
    in_signed_c = (i_ALUctr == OP_DIV) || (i_ALUctr == OP_REM);
    in_rem_c    = (i_ALUctr == OP_REM) || (i_ALUctr == OP_REMU);
    if (i_word_cut) begin
      a_ext_c = {{(XLEN-WLEN){in_signed_c & i_src1[WLEN-1]}}, i_src1[WLEN-1:0]};
      b_ext_c = {{(XLEN-WLEN){in_signed_c & i_src2[WLEN-1]}}, i_src2[WLEN-1:0]};
    end else begin
      a_ext_c = i_src1;
      b_ext_c = i_src2;
    end
    a_neg_c    = in_signed_c & a_ext_c[XLEN-1];
    b_neg_c    = in_signed_c & b_ext_c[XLEN-1];
    a_mag_c    = a_neg_c ? neg(a_ext_c) : a_ext_c;
    b_mag_c    = b_neg_c ? neg(b_ext_c) : b_ext_c;
    div_zero_c = (b_ext_c == '0);
    ovf_c      = in_signed_c && (b_ext_c == '1) &&
                 (a_ext_c == (i_word_cut ? MIN_W : MIN_D));
    if (div_zero_c) special_c = in_rem_c ? a_ext_c : '1;
    else            special_c = in_rem_c ? '0 : a_ext_c;
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits
  always_comb begin
    partial_c  = {rem_q, quo_q[XLEN-1]};
    diff_c     = partial_c - {1'b0, dvs_q};
    ge_c       = (partial_c >= {1'b0, dvs_q});
    step_rem_c = ge_c ? diff_c[XLEN-1:0] : partial_c[XLEN-1:0];
    step_quo_c = {quo_q[XLEN-2:0], ge_c};
    if (is_rem_q) final_c = r_neg_q ? neg(step_rem_c) : step_rem_c;
    else          final_c = q_neg_q ? neg(step_quo_c) : step_quo_c;
  end

  // Next-state and datapath update
  always_comb begin
    state_nx  = state_q;
    cnt_nx    = cnt_q;
    quo_nx    = quo_q;
    rem_nx    = rem_q;
    dvs_nx    = dvs_q;
    is_rem_nx = is_rem_q;
    word_nx   = word_q;
    q_neg_nx  = q_neg_q;
    r_neg_nx  = r_neg_q;
    res_nx    = '0;
    unique case (state_q)
      S_IDLE: begin
        if (i_valid && op_ok_c) begin
          is_rem_nx = in_rem_c;
          word_nx   = i_word_cut;
          q_neg_nx  = a_neg_c ^ b_neg_c;
          r_neg_nx  = a_neg_c;
          cnt_nx    = '0;
          rem_nx    = '0;
          dvs_nx    = b_mag_c;
          // left-align the dividend so both widths shift out MSB-first
          quo_nx    = i_word_cut ? {a_mag_c[WLEN-1:0], {(XLEN-WLEN){1'b0}}} : a_mag_c;
          if (div_zero_c || ovf_c) begin
            state_nx = S_DONE;
            res_nx   = fit(special_c, i_word_cut);
          end else begin
            state_nx = S_CALC;
          end
        end
      end
      S_CALC: begin
        quo_nx = step_quo_c;
        rem_nx = step_rem_c;
        cnt_nx = cnt_q + CNT_W'(1);
        if (cnt_q == (word_q ? LAST_W : LAST_D)) begin
          state_nx = S_DONE;
          res_nx   = fit(final_c, word_q);
        end
      end
      S_DONE: begin
        res_nx = o_result;
        if (i_out_ready) begin
          state_nx = S_IDLE;
          res_nx   = '0;
        end
      end
      default: state_nx = S_IDLE;
    endcase
    if (i_flush) begin
      state_nx = S_IDLE;
      cnt_nx   = '0;
      res_nx   = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_nx;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      is_rem_q <= 1'b0;
      word_q   <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_nx;
      quo_q    <= quo_nx;
      rem_q    <= rem_nx;
      dvs_q    <= dvs_nx;
      is_rem_q <= is_rem_nx;
      word_q   <= word_nx;
      q_neg_q  <= q_neg_nx;
      r_neg_q  <= r_neg_nx;
    end
  end

  // Status outputs are registered copies of the next-state decode
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ready     <= 1'b1;
      o_out_valid <= 1'b0;
      o_busy      <= 1'b0;
      o_result    <= '0;
    end else begin
      o_ready     <= (state_nx == S_IDLE);
      o_out_valid <= (state_nx == S_DONE);
      o_busy      <= (state_nx != S_IDLE);
      o_result    <= res_nx;
    end
  end

endmodule

// File: tb/tb_ysyx_22050710_div_seq.sv
// Directed bench for ysyx_22050710_div_seq.
// Latency is counted in clock edges after the accepting edge.
module tb_ysyx_22050710_div_seq;

  localparam logic [4:0] OP_DIV  = 5'b01011;
  localparam logic [4:0] OP_DIVU = 5'b01100;
  localparam logic [4:0] OP_REM  = 5'b01101;
  localparam logic [4:0] OP_REMU = 5'b01110;

  logic        i_clk, i_rst_n, i_valid, o_ready, i_word_cut, i_flush;
  logic        o_out_valid, i_out_ready, o_busy;
  logic [4:0]  i_ALUctr;
  logic [63:0] i_src1, i_src2, o_result;

  int n_vec  = 0;
  int n_miss = 0;

  ysyx_22050710_div_seq dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_ALUctr    (i_ALUctr),
    .i_word_cut  (i_word_cut),
    .i_src1      (i_src1),
    .i_src2      (i_src2),
    .i_flush     (i_flush),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_result    (o_result),
    .o_busy      (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [4:0] ctr, input logic wc, input logic [63:0] a, input logic [63:0] b);
    @(negedge i_clk);
    i_ALUctr = ctr; i_word_cut = wc; i_src1 = a; i_src2 = b; i_valid = 1'b1;
    @(posedge i_clk);
    #1 i_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!o_out_valid && lat < 200) begin
      @(posedge i_clk);
      #1 lat++;
    end
  endtask

  task automatic retire(input string tag);
    i_out_ready = 1'b1;
    @(posedge i_clk);
    #1 i_out_ready = 1'b0;
    chk({tag, "_ready_after"}, 64'(o_ready), 64'd1);
    chk({tag, "_result_idle"}, o_result, 64'd0);
  endtask

  task automatic do_op(input string tag, input logic [4:0] ctr, input logic wc,
                       input logic [63:0] a, input logic [63:0] b,
                       input int exp_lat, input logic [63:0] exp_res);
    int lat;
    issue(ctr, wc, a, b);
    wait_done(lat);
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_res"}, o_result, exp_res);
    retire(tag);
  endtask

  initial begin
    int lat;
    bit seen;
    i_rst_n = 1'b0; i_valid = 1'b0; i_ALUctr = '0; i_word_cut = 1'b0;
    i_src1 = '0; i_src2 = '0; i_flush = 1'b0; i_out_ready = 1'b0;
    #12;
    chk("rst_ready", 64'(o_ready), 64'd1);
    chk("rst_valid", 64'(o_out_valid), 64'd0);
    chk("rst_busy",  64'(o_busy), 64'd0);
    chk("rst_result", o_result, 64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // main function, both widths and signednesses
    do_op("divu64",  OP_DIVU, 1'b0, 64'd100, 64'd7, 64, 64'd14);
    do_op("remu64",  OP_REMU, 1'b0, 64'd100, 64'd7, 64, 64'd2);
    do_op("div64",   OP_DIV,  1'b0, -64'sd20, 64'd3, 64, 64'hFFFF_FFFF_FFFF_FFFA);
    do_op("rem64",   OP_REM,  1'b0, -64'sd20, 64'd3, 64, 64'hFFFF_FFFF_FFFF_FFFE);
    do_op("divw",    OP_DIV,  1'b1, 64'h0000_0000_FFFF_FFEC, 64'd3, 32, 64'hFFFF_FFFF_FFFF_FFFA);
    do_op("remw",    OP_REM,  1'b1, 64'h0000_0000_FFFF_FFEC, 64'd3, 32, 64'hFFFF_FFFF_FFFF_FFFE);
    do_op("divuw_hi", OP_DIVU, 1'b1, 64'h1234_5678_0000_0064, 64'hABCD_0000_0000_0007, 32, 64'd14);
    do_op("divuw_sx", OP_DIVU, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd1, 32, 64'hFFFF_FFFF_FFFF_FFFE);

    // single-cycle special cases: DONE straight from the accepting edge
    do_op("divw_ovf", OP_DIV,  1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 0, 64'hFFFF_FFFF_8000_0000);
    do_op("remw_ovf", OP_REM,  1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 0, 64'd0);
    do_op("divu_z",   OP_DIVU, 1'b0, 64'd5, 64'd0, 0, 64'hFFFF_FFFF_FFFF_FFFF);
    do_op("remu_z",   OP_REMU, 1'b0, 64'd5, 64'd0, 0, 64'd5);
    do_op("divuw_z",  OP_DIVU, 1'b1, 64'd5, 64'h1_0000_0000, 0, 64'hFFFF_FFFF_FFFF_FFFF);

    // unsupported opcode is ignored
    issue(5'b00000, 1'b0, 64'd100, 64'd7);
    chk("bad_op_ready", 64'(o_ready), 64'd1);
    chk("bad_op_busy",  64'(o_busy), 64'd0);

    // flush partway through CALC
    issue(OP_DIVU, 1'b0, 64'd100, 64'd7);
    repeat (10) @(posedge i_clk);
    #1 i_flush = 1'b1;
    @(posedge i_clk);
    #1 i_flush = 1'b0;
    chk("flush_ready", 64'(o_ready), 64'd1);
    chk("flush_busy",  64'(o_busy), 64'd0);
    seen = 1'b0;
    repeat (80) begin
      @(posedge i_clk);
      #1 if (o_out_valid) seen = 1'b1;
    end
    chk("flush_no_valid", 64'(seen), 64'd0);
    do_op("after_flush", OP_DIVU, 1'b0, 64'd100, 64'd7, 64, 64'd14);

    // consumer stall holds the result
    issue(OP_REMU, 1'b1, 64'd100, 64'd7);
    wait_done(lat);
    chk("hold_lat", 64'(lat), 64'd32);
    for (int i = 0; i < 5; i++) begin
      @(posedge i_clk);
      #1;
      chk($sformatf("hold_valid_%0d", i), 64'(o_out_valid), 64'd1);
      chk($sformatf("hold_res_%0d", i), o_result, 64'd2);
    end
    retire("hold");

    // asynchronous reset mid-CALC, then accept on the first edge
    issue(OP_DIVU, 1'b0, 64'd100, 64'd7);
    repeat (5) @(posedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    chk("arst_ready",  64'(o_ready), 64'd1);
    chk("arst_valid",  64'(o_out_valid), 64'd0);
    chk("arst_busy",   64'(o_busy), 64'd0);
    chk("arst_result", o_result, 64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_ALUctr = OP_DIVU; i_word_cut = 1'b0; i_src1 = 64'd100; i_src2 = 64'd7; i_valid = 1'b1;
    @(posedge i_clk);
    #1 i_valid = 1'b0;
    chk("arst_accept_busy", 64'(o_busy), 64'd1);
    wait_done(lat);
    chk("arst_lat", 64'(lat), 64'd64);
    chk("arst_res", o_result, 64'd14);
    retire("arst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
